// File: rtl/platform_pkg.sv
// Shared types and constants for the platform scroller: segment record,
// key codes, lookup FSM encoding and the segment-table reset image.
package platform_pkg;

  localparam logic [7:0]  KEY_A    = 8'h04;
  localparam logic [7:0]  KEY_D    = 8'h07;
  localparam logic [13:0] NO_FLOOR = 14'h3FFF;

  typedef struct packed {
    logic [13:0] x;
    logic [13:0] top;
    logic [13:0] bot;
    logic        valid;
  } seg_t;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_SCAN = 2'd1,
    LK_DONE = 2'd2
  } lookup_state_e;

  // Power-up map: a low floor, one raised step, remaining entries parked at map end.
  function automatic seg_t seg_reset_value(input int idx, input int map_len);
    seg_t s;
    s.valid = 1'b1;
    s.top   = 14'd400;
    s.bot   = 14'd450;
    if (idx == 0) begin
      s.x   = 14'd0;
      s.top = 14'd300;
      s.bot = 14'd350;
    end else if (idx == 1) begin
      s.x = 14'd400;
    end else begin
      s.x = 14'(map_len);
    end
    return s;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous VGA frame clock into the Clk domain and emits a
// single-cycle pulse on each of its rising edges.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= frame_clk;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign frame_tick = sync2 & ~sync_prev;

endmodule

// File: rtl/platform_scroller.sv
// Side-scrolling camera, segment floor lookup and per-pixel platform test.
// Optional build macro PLATFORM_GAP_EN turns segments with valid=0 into gaps.
module platform_scroller
  import platform_pkg::*;
#(
  parameter int NUM_SEG  = 8,
  parameter int MAP_LEN  = 4473,
  parameter int SPEED    = 6,
  parameter int SCREEN_W = 640
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_clk,
  input  logic [7:0]                 keycode,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic [13:0]                player_x,
  input  logic                       seg_wr_en,
  input  logic [$clog2(NUM_SEG)-1:0] seg_wr_idx,
  input  logic [13:0]                seg_wr_x,
  input  logic [13:0]                seg_wr_top,
  input  logic [13:0]                seg_wr_bot,
  input  logic                       seg_wr_valid,
  output logic [13:0]                left_bound,
  output logic                       can_move,
  output logic [13:0]                top,
  output logic [13:0]                bot,
  output logic                       is_platform,
  output logic                       lookup_busy,
  output logic [1:0]                 lookup_state
);

  localparam int IDX_W = $clog2(NUM_SEG);
  localparam logic [1:0]       S_IDLE = 2'(LK_IDLE);
  localparam logic [1:0]       S_SCAN = 2'(LK_SCAN);
  localparam logic [1:0]       S_DONE = 2'(LK_DONE);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_SEG - 1);
  localparam logic [14:0]      LB_MAX = 15'(MAP_LEN - SCREEN_W);
  localparam logic [14:0]      STEP   = 15'(SPEED);

  logic frame_tick;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  // Camera: clamps are decided on a 15-bit copy so nothing wraps.
  logic [14:0] lb_ext;
  assign lb_ext = {1'b0, left_bound};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      left_bound <= '0;
      can_move   <= 1'b1;
    end else if (frame_tick) begin
      if (keycode == KEY_A) begin
        if (lb_ext < STEP) begin
          left_bound <= '0;
          can_move   <= 1'b1;
        end else begin
          left_bound <= 14'(lb_ext - STEP);
          can_move   <= 1'b0;
        end
      end else if (keycode == KEY_D) begin
        if (lb_ext + STEP > LB_MAX) begin
          left_bound <= 14'(LB_MAX);
          can_move   <= 1'b1;
        end else begin
          left_bound <= 14'(lb_ext + STEP);
          can_move   <= 1'b0;
        end
      end else begin
        can_move <= 1'b0;
      end
    end
  end

  seg_t seg_tab [NUM_SEG];

  // Entry 0 always starts at x=0, so its x is never written.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SEG; i++) seg_tab[i] <= seg_reset_value(i, MAP_LEN);
    end else if (seg_wr_en && (32'(seg_wr_idx) < 32'(NUM_SEG))) begin
      seg_tab[seg_wr_idx].top <= seg_wr_top;
      seg_tab[seg_wr_idx].bot <= seg_wr_bot;
      if (seg_wr_idx != '0) seg_tab[seg_wr_idx].x <= seg_wr_x;
`ifdef PLATFORM_GAP_EN
      seg_tab[seg_wr_idx].valid <= seg_wr_valid;
`endif
    end
  end

`ifndef PLATFORM_GAP_EN
  logic valid_unused;
  assign valid_unused = seg_wr_valid;
`endif

  logic [1:0]       state;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] sel_idx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      scan_idx <= ONE;
      sel_idx  <= '0;
      top      <= 14'd300;
      bot      <= 14'd350;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state    <= S_SCAN;
            scan_idx <= ONE;
          end
        end
        S_SCAN: begin
          if (frame_tick || seg_wr_en) begin
            scan_idx <= ONE;
          end else if (player_x < seg_tab[scan_idx].x) begin
            sel_idx <= scan_idx - ONE;
            state   <= S_DONE;
          end else if (scan_idx == LAST) begin
            sel_idx <= LAST;
            state   <= S_DONE;
          end else begin
            scan_idx <= scan_idx + ONE;
          end
        end
        S_DONE: begin
          if (seg_tab[sel_idx].valid) begin
            top <= seg_tab[sel_idx].top;
            bot <= seg_tab[sel_idx].bot;
          end else begin
            top <= NO_FLOOR;
            bot <= NO_FLOOR;
          end
          scan_idx <= ONE;
          state    <= frame_tick ? S_SCAN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lookup_busy  = (state != S_IDLE);
  assign lookup_state = state;

  // Pixel test: the sum deliberately wraps at 14 bits.
  logic [13:0]      pix_x;
  logic [13:0]      draw_y_ext;
  logic [IDX_W-1:0] pix_seg;

  assign pix_x      = {4'd0, DrawX} + left_bound;
  assign draw_y_ext = {4'd0, DrawY};

  always_comb begin
    pix_seg = '0;
    for (int k = 1; k < NUM_SEG; k++) begin
      if (pix_x >= seg_tab[k].x) pix_seg = IDX_W'(k);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_platform <= 1'b0;
    end else begin
      is_platform <= ({18'd0, pix_x} < 32'(MAP_LEN)) && seg_tab[pix_seg].valid &&
                     (draw_y_ext >= seg_tab[pix_seg].top) &&
                     (draw_y_ext <= seg_tab[pix_seg].bot);
    end
  end

endmodule

// File: doc/platform_scroller.md
PLATFORM_SCROLLER -- requirements
Module: platform_scroller

Interface
REQ-001 SHALL have parameter NUM_SEG, default 8: number of platform segments (2..16).
REQ-002 SHALL have parameter MAP_LEN, default 4473: total map length in map pixels.
REQ-003 SHALL have parameter SPEED, default 6: camera scroll step per frame.
REQ-004 SHALL have parameter SCREEN_W, default 640: visible width in pixels.
REQ-005 SHALL have port Clk  input  1  system clock.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port frame_clk  input  1  VGA frame tick, asynchronous to Clk.
REQ-008 SHALL have port keycode  input  8  keyboard code; 0x04 = A (left), 0x07 = D (right).
REQ-009 SHALL have ports DrawX, DrawY  input  10 each  current pixel being drawn.
REQ-010 SHALL have port player_x  input  14  player position in map coordinates.
REQ-011 SHALL have ports seg_wr_en (1), seg_wr_idx ($clog2(NUM_SEG)), seg_wr_x (14), seg_wr_top (14), seg_wr_bot (14), seg_wr_valid (1)  input  segment-table write port.
REQ-012 SHALL have port left_bound  output  14  camera left edge in map coordinates.
REQ-013 SHALL have port can_move  output  1  player may move on screen (camera not scrolling).
REQ-014 SHALL have ports top, bot  output  14 each  floor band of the segment under player_x.
REQ-015 SHALL have port is_platform  output  1  current pixel lies on a platform.
REQ-016 SHALL have port lookup_busy  output  1  segment scan in progress.

Function
REQ-017 SHALL pass frame_clk through a two-flop synchroniser and raise a one-cycle frame_tick on its rising edge.
REQ-018 On frame_tick with keycode 0x04: left_bound SHALL become max(left_bound-SPEED, 0); can_move SHALL be 1 if clamped or already 0, otherwise 0.
REQ-019 On frame_tick with keycode 0x07: left_bound SHALL become min(left_bound+SPEED, MAP_LEN-SCREEN_W); can_move SHALL be 1 if clamped or already at max, otherwise 0.
REQ-020 On frame_tick with any other keycode: left_bound SHALL hold and can_move SHALL be 0.
REQ-021 Segment i SHALL span [x_i, x_(i+1)); the last segment SHALL span to MAP_LEN; the table SHALL be ascending by x, and entry 0 x SHALL be forced to 0 regardless of writes.
REQ-022 The lookup FSM SHALL have states IDLE, SCAN, DONE: IDLE->SCAN on frame_tick; SCAN tests one index per cycle, from 1 to NUM_SEG-1; on the first i with player_x < x_i, or when the scan is exhausted, ->DONE; DONE latches top/bot of segment i-1 (last segment if exhausted) and ->IDLE.
REQ-023 Lookup latency SHALL be at most NUM_SEG+1 cycles after frame_tick; lookup_busy SHALL be high in SCAN and DONE.
REQ-024 A frame_tick or seg_wr_en while in SCAN SHALL restart the scan at index 1; top/bot SHALL hold until DONE.
REQ-025 A write SHALL take effect on the next Clk edge; a write to index 0 SHALL update only top, bot and valid.
REQ-026 is_platform SHALL be registered with 1-cycle latency: 1 iff DrawY is in [top_k, bot_k] of the segment k containing DrawX+left_bound (14-bit sum); 0 if the sum is >= MAP_LEN.
REQ-027 All coordinate arithmetic SHALL be 14-bit unsigned, with the clamps in REQ-018/019 computed before truncation (no wrap-around).

Reset
REQ-028 With Reset_n low: left_bound=0, can_move=1, top=300, bot=350, is_platform=0, lookup_busy=0, FSM=IDLE, synchroniser cleared.
REQ-029 Table reset values SHALL be: seg0 {0,300,350}, seg1 {400,400,450}, seg2..N-1 {MAP_LEN,400,450}, all valid.
REQ-030 Reset asserted mid-scan SHALL abort the scan immediately; no partial top/bot update SHALL occur.

Configuration
REQ-031 With PLATFORM_GAP_EN defined: a segment with valid=0 SHALL be a gap, with is_platform=0 over it and top=bot=14'h3FFF when the player is in it.
REQ-032 Without PLATFORM_GAP_EN: seg_wr_valid SHALL be ignored and all segments SHALL be solid.

Structure
REQ-033 Package platform_pkg SHALL hold the seg_t struct {x, top, bot, valid}, the key constants KEY_A/KEY_D, and the lookup-state enum.
REQ-034 The synchroniser and edge detector SHALL be the sub-module frame_tick_sync.

Verification
REQ-035 Reset, then 12 frames with keycode 0x07 -> left_bound=72, can_move=0; top=300, bot=350 (player_x=100).
REQ-036 left_bound=3, one frame with 0x04 -> left_bound=0, can_move=1; a further frame -> left_bound still 0.
REQ-037 player_x=450, one frame -> top=400, bot=450 within NUM_SEG+1 cycles; lookup_busy deasserts afterwards.
REQ-038 Write seg2 {800,200,250} during SCAN with player_x=900 -> scan restarts; final top=200, bot=250.
REQ-039 left_bound=0, DrawX=410, DrawY=420 -> is_platform=1 one cycle later; DrawY=320 -> is_platform=0.
REQ-040 PLATFORM_GAP_EN defined, seg1 valid=0, player_x=500 -> top=bot=14'h3FFF; is_platform=0 for DrawX=500, DrawY=420.
